// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with a 2-entry skid buffer.
//
// The immediate is decoded combinationally from the incoming instruction word.
// It is registered when the input transfer happens. The tag, normally the PC,
// travels with the instruction. Unknown opcodes are passed through with
// imm = 0 and fmt = NONE, so no entry is ever dropped.
//
// Parameters:
//   XLEN  - immediate width. Only 32 and 64 are legal.
//   TAG_W - width of the sideband tag.
//
// Ports:
//   clk, reset_n         - clock; synchronous active-low reset
//   flush                - invalidates both entries; the data registers keep their values
//   in_valid/in_ready    - input handshake (instruc, in_tag)
//   out_valid/out_ready  - output handshake (imm_data, fmt, out_tag)
//   fmt encoding         - 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//
// Handshake: a transfer happens on a side when valid && ready are both high
// at the rising edge. A producer holds its payload stable while valid is high
// and ready is low. in_ready depends only on the registered skid_valid
// (gated by reset_n), so there is no combinational path from out_ready.
//
// Optional feature (macro IMM_GEN_SHAMT_EN): shift-immediate instructions
// (OP-IMM / OP-IMM-32 with funct3 001/101) produce a zero-extended shift
// amount instead of the sign-extended I immediate.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_data,
  output logic [2:0]       fmt,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  // ---------------- combinational decode ----------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     imm32;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;

  assign opcode = instruc[6:0];
  assign funct3 = instruc[14:12];

  always_comb begin
    imm32   = 32'd0;
    dec_fmt = FMT_NONE;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
        imm32   = {{20{instruc[31]}}, instruc[31:20]};
        dec_fmt = FMT_I;
`ifdef IMM_GEN_SHAMT_EN
        // The top bit of imm32 is left at 0, so the sign extension below
        // acts as a zero extension.
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          if ((opcode == 7'b0010011) && (XLEN == 64))
            imm32 = {26'd0, instruc[25:20]};
          else if ((opcode == 7'b0010011) || (opcode == 7'b0011011))
            imm32 = {27'd0, instruc[24:20]};
        end
`endif
      end
      7'b0100011: begin
        imm32   = {{20{instruc[31]}}, instruc[31:25], instruc[11:7]};
        dec_fmt = FMT_S;
      end
      7'b1100011: begin
        imm32   = {{20{instruc[31]}}, instruc[7], instruc[30:25], instruc[11:8], 1'b0};
        dec_fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        imm32   = {instruc[31:12], 12'd0};
        dec_fmt = FMT_U;
      end
      7'b1101111: begin
        imm32   = {{12{instruc[31]}}, instruc[19:12], instruc[20], instruc[30:21], 1'b0};
        dec_fmt = FMT_J;
      end
      default: begin
        imm32   = 32'd0;
        dec_fmt = FMT_NONE;
      end
    endcase
    // Bit 31 of imm32 is the sign for every signed format. Extend it to XLEN.
    dec_imm = XLEN'($signed(imm32));
  end

  // ---------------- storage: main (drives outputs) + skid ----------------
  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [2:0]       skid_fmt;
  logic [TAG_W-1:0] skid_tag;
  logic             in_fire;
  logic             out_fire;

  assign in_ready = reset_n & ~skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      imm_data   <= '0;
      fmt        <= FMT_NONE;
      out_tag    <= '0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_fmt   <= FMT_NONE;
      skid_tag   <= '0;
    end else if (flush) begin
      // Only the valid bits are killed. Any same-cycle input is dropped.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid) begin
      // Main is empty, which implies skid is also empty.
      if (in_fire) begin
        out_valid <= 1'b1;
        imm_data  <= dec_imm;
        fmt       <= dec_fmt;
        out_tag   <= in_tag;
      end
    end else if (out_fire) begin
      if (skid_valid) begin
        imm_data   <= skid_imm;
        fmt        <= skid_fmt;
        out_tag    <= skid_tag;
        // Unreachable while in_ready is !skid_valid, but this keeps the
        // entry rather than losing it.
        skid_valid <= in_fire;
        if (in_fire) begin
          skid_imm <= dec_imm;
          skid_fmt <= dec_fmt;
          skid_tag <= in_tag;
        end
      end else if (in_fire) begin
        imm_data <= dec_imm;
        fmt      <= dec_fmt;
        out_tag  <= in_tag;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      // Output is stalled. Park the new entry in skid.
      skid_valid <= 1'b1;
      skid_imm   <= dec_imm;
      skid_fmt   <= dec_fmt;
      skid_tag   <= in_tag;
    end
  end

  // A skid drain and an input transfer must never coincide.
  a_no_skid_overlap : assert property (@(posedge clk) disable iff (!reset_n)
    !(out_fire && skid_valid && in_fire));

endmodule
